// File: rtl/dot_unit_pkg.sv
// Shared dot-product control encoding, used by both the instruction decoder and dot_unit.
package dot_unit_pkg;

    localparam int DOT_CTRL_WIDTH = 2;

    typedef enum logic [DOT_CTRL_WIDTH-1:0] {
        DOT_NONE  = 2'b00,
        DOT_SHIFT = 2'b01,
        DOT_ACC   = 2'b10,
        DOT_CLR   = 2'b11
    } dot_ctrl_e;

    // A cycle carries a real op only when it is valid and names an operation.
    function automatic logic dot_op_accept(input logic valid, input logic [DOT_CTRL_WIDTH-1:0] ctrl);
        return valid && (ctrl != DOT_NONE);
    endfunction

endpackage

// File: rtl/dot_unit_adder_tree.sv
// Pipelined lane-reduction tree: input register plus one register per adder level.
// A valid bit and an opaque sideband word ride along with the partial sums.
module adder_tree #(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int SB_WIDTH   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
    input  logic [SB_WIDTH-1:0]             in_sb,
    output logic                            out_valid,
    output logic [DATA_WIDTH-1:0]           out_sum,
    output logic [SB_WIDTH-1:0]             out_sb,
    output logic [$clog2(NUM_LANES):0]      stage_valid
);

    localparam int DEPTH = $clog2(NUM_LANES);

    genvar gi;
    generate
        for (gi = 0; gi <= DEPTH; gi++) begin : lvl
            localparam int NODES = NUM_LANES >> gi;

            logic [DATA_WIDTH-1:0] node_reg [NODES];
            logic                  vld_reg;
            logic [SB_WIDTH-1:0]   sb_reg;

            if (gi == 0) begin : g_in
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        vld_reg <= 1'b0;
                        sb_reg  <= '0;
                        for (int j = 0; j < NODES; j++) begin
                            node_reg[j] <= '0;
                        end
                    end else begin
                        vld_reg <= in_valid;
                        // Data and sideband only move with a real op to cut toggling.
                        if (in_valid) begin
                            sb_reg <= in_sb;
                            for (int j = 0; j < NODES; j++) begin
                                node_reg[j] <= in_data[j*DATA_WIDTH +: DATA_WIDTH];
                            end
                        end
                    end
                end
            end else begin : g_add
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        vld_reg <= 1'b0;
                        sb_reg  <= '0;
                        for (int j = 0; j < NODES; j++) begin
                            node_reg[j] <= '0;
                        end
                    end else begin
                        vld_reg <= lvl[gi-1].vld_reg;
                        if (lvl[gi-1].vld_reg) begin
                            sb_reg <= lvl[gi-1].sb_reg;
                            for (int j = 0; j < NODES; j++) begin
                                node_reg[j] <= lvl[gi-1].node_reg[2*j] + lvl[gi-1].node_reg[2*j+1];
                            end
                        end
                    end
                end
            end

            assign stage_valid[gi] = vld_reg;
        end
    endgenerate

    assign out_valid = lvl[DEPTH].vld_reg;
    assign out_sum   = lvl[DEPTH].node_reg[0];
    assign out_sb    = lvl[DEPTH].sb_reg;

endmodule

// File: rtl/dot_unit.sv
// Dot-product engine: reduces PE lane products and shifts/accumulates/clears a result vector.
// Optional build macro DOT_SATURATE_EN makes the accumulate add saturate instead of wrap.
module dot_unit
    import dot_unit_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [DOT_CTRL_WIDTH-1:0]       dot_ctrl,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] products,
    input  logic [ADDR_WIDTH-1:0]           in_addr,
    output logic                            out_valid,
    output logic [ADDR_WIDTH-1:0]           out_addr,
    output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
    output logic                            busy
);

    localparam int DEPTH    = $clog2(NUM_LANES);
    localparam int SB_WIDTH = DOT_CTRL_WIDTH + ADDR_WIDTH;

    logic                      accept;
    logic                      tree_valid;
    logic [DATA_WIDTH-1:0]     tree_sum;
    logic [SB_WIDTH-1:0]       tree_sb;
    logic [DEPTH:0]            tree_stage_valid;
    dot_ctrl_e                 fin_ctrl;
    logic [ADDR_WIDTH-1:0]     fin_addr;
    logic [DATA_WIDTH-1:0]     acc_value;
    logic                      out_valid_reg;
    logic [ADDR_WIDTH-1:0]     out_addr_reg;

    assign accept = dot_op_accept(in_valid, dot_ctrl);

    adder_tree #(
        .NUM_LANES  (NUM_LANES),
        .DATA_WIDTH (DATA_WIDTH),
        .SB_WIDTH   (SB_WIDTH)
    ) u_tree (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (accept),
        .in_data     (products),
        .in_sb       ({dot_ctrl, in_addr}),
        .out_valid   (tree_valid),
        .out_sum     (tree_sum),
        .out_sb      (tree_sb),
        .stage_valid (tree_stage_valid)
    );

    assign fin_ctrl = dot_ctrl_e'(tree_sb[SB_WIDTH-1 -: DOT_CTRL_WIDTH]);
    assign fin_addr = tree_sb[ADDR_WIDTH-1:0];

`ifdef DOT_SATURATE_EN
    logic [DATA_WIDTH:0] acc_wide;

    // One guard bit: the two top bits disagree exactly when the signed add overflowed.
    assign acc_wide = {lane[0].val_reg[DATA_WIDTH-1], lane[0].val_reg}
                    + {tree_sum[DATA_WIDTH-1], tree_sum};

    always_comb begin
        acc_value = acc_wide[DATA_WIDTH-1:0];
        if (acc_wide[DATA_WIDTH] != acc_wide[DATA_WIDTH-1]) begin
            acc_value = acc_wide[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                             : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end
`else
    assign acc_value = lane[0].val_reg + tree_sum;
`endif

    // Read-modify-write lives only here, so back-to-back ops need no forwarding.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : lane
            logic [DATA_WIDTH-1:0] val_reg;

            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        val_reg <= '0;
                    end else if (tree_valid) begin
                        case (fin_ctrl)
                            DOT_SHIFT: val_reg <= tree_sum;
                            DOT_ACC:   val_reg <= acc_value;
                            DOT_CLR:   val_reg <= '0;
                            default:   val_reg <= val_reg;
                        endcase
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        val_reg <= '0;
                    end else if (tree_valid) begin
                        case (fin_ctrl)
                            DOT_SHIFT: val_reg <= lane[gi-1].val_reg;
                            DOT_CLR:   val_reg <= '0;
                            default:   val_reg <= val_reg;
                        endcase
                    end
                end
            end

            assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = val_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_addr_reg  <= '0;
        end else begin
            out_valid_reg <= tree_valid;
            if (tree_valid) begin
                out_addr_reg <= fin_addr;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_addr  = out_addr_reg;
    assign busy      = |tree_stage_valid;

endmodule

// File: tb/tb_dot_unit.sv
// Scoreboard bench for dot_unit: a vector-level reference model predicts every write-back.
module tb_dot_unit;

    localparam int NL = 4;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int L  = 3;
    localparam int VW = NL*DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [1:0]    dot_ctrl = 2'b00;
    logic [VW-1:0] products = '0;
    logic [AW-1:0] in_addr = '0;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [VW-1:0] out_data;
    logic          busy;

    dot_unit #(.NUM_LANES(NL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .dot_ctrl  (dot_ctrl),
        .products  (products),
        .in_addr   (in_addr),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [VW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    logic [DW-1:0] model [NL];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [VW-1:0] pk(input logic [DW-1:0] l3, input logic [DW-1:0] l2,
                                         input logic [DW-1:0] l1, input logic [DW-1:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < NL; i++) v[i*DW +: DW] = model[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference semantics: the vector after each op, in issue order.
    task automatic model_apply(input logic [1:0] c, input logic [VW-1:0] p);
        logic [DW-1:0] sum;
        longint        s;
        sum = '0;
        for (int i = 0; i < NL; i++) sum = sum + p[i*DW +: DW];
        case (c)
            2'b01: begin
                for (int i = NL-1; i > 0; i--) model[i] = model[i-1];
                model[0] = sum;
            end
            2'b10: begin
                s = longint'($signed(model[0])) + longint'($signed(sum));
`ifdef DOT_SATURATE_EN
                if (s > 64'sd2147483647) s = 64'sd2147483647;
                if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
                model[0] = s[DW-1:0];
            end
            2'b11: for (int i = 0; i < NL; i++) model[i] = '0;
            default: ;
        endcase
    endtask

    task automatic issue(input logic v, input logic [1:0] c, input logic [VW-1:0] p, input logic [AW-1:0] a);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        dot_ctrl = c;
        products = p;
        in_addr  = a;
        if (v && c != 2'b00) begin
            model_apply(c, p);
            e.addr = a;
            e.data = model_vec();
            e.cyc  = cyc + 1 + L;
            sb_q.push_back(e);
            $display("issue ctrl=%0d addr=%h products=%h", c, a, p);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            dot_ctrl = 2'b00;
        end
    endtask

    // Monitor: every write-back pulse must match the oldest outstanding prediction.
    always @(posedge clk) begin
        #1;
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid actual=1 required=0 addr=%h data=%h", out_addr, out_data);
            end else begin
                mon_e = sb_q.pop_front();
                $display("writeback addr=%h data=%h", out_addr, out_data);
                check("out_addr", VW'(out_addr), VW'(mon_e.addr));
                check("out_data", out_data, mon_e.data);
                check("latency_cycle", VW'(cyc), VW'(mon_e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]    rc;
        logic [VW-1:0] rp;
        logic [DW-1:0] sat_exp;

        for (int i = 0; i < NL; i++) model[i] = '0;

        #1;
        check("reset_out_valid", VW'(out_valid), '0);
        check("reset_out_data", out_data, '0);
        check("reset_out_addr", VW'(out_addr), '0);
        check("reset_busy", VW'(busy), '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2);

        issue(1'b1, 2'b01, pk(4, 3, 2, 1), 10'h010);
        @(posedge clk); #1;
        check("busy_in_flight", VW'(busy), VW'(1));
        idle(5);
        check("plan_shift", out_data, pk(0, 0, 0, 10));

        issue(1'b1, 2'b10, pk(1, 1, 1, 1), 10'h011);
        issue(1'b1, 2'b01, pk(5, 5, 5, 5), 10'h012);
        idle(6);
        check("plan_acc_then_shift", out_data, pk(0, 0, 14, 20));

        issue(1'b1, 2'b11, pk(9, 9, 9, 9), 10'h020);
        idle(6);
        check("plan_clear", out_data, '0);
        check("plan_clear_addr", VW'(out_addr), VW'(10'h020));

        issue(1'b1, 2'b01, pk(0, 0, 0, 32'h7FFF_FFFF), 10'h030);
        issue(1'b1, 2'b10, pk(0, 0, 0, 1), 10'h031);
        idle(6);
`ifdef DOT_SATURATE_EN
        sat_exp = 32'h7FFF_FFFF;
`else
        sat_exp = 32'h8000_0000;
`endif
        check("plan_acc_overflow", out_data, pk(0, 0, 0, sat_exp));

        // Bubbles: neither may enter the pipeline or disturb the vector.
        issue(1'b1, 2'b00, pk(7, 7, 7, 7), 10'h040);
        @(posedge clk); #1;
        check("bubble_ctrl_none_busy", VW'(busy), '0);
        issue(1'b0, 2'b01, pk(7, 7, 7, 7), 10'h041);
        @(posedge clk); #1;
        check("bubble_invalid_busy", VW'(busy), '0);
        idle(5);
        check("bubble_vector_held", out_data, model_vec());

        // Reset with two shifts in flight.
        issue(1'b1, 2'b01, pk(1, 0, 0, 0), 10'h050);
        issue(1'b1, 2'b01, pk(2, 0, 0, 0), 10'h051);
        @(negedge clk);
        in_valid = 1'b0;
        dot_ctrl = 2'b00;
        rst = 1'b1;
        #1;
        check("midreset_out_data", out_data, '0);
        check("midreset_out_valid", VW'(out_valid), '0);
        check("midreset_out_addr", VW'(out_addr), '0);
        check("midreset_busy", VW'(busy), '0);
        sb_q.delete();
        for (int i = 0; i < NL; i++) model[i] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(8);
        check("post_reset_busy", VW'(busy), '0);

        for (int n = 0; n < 300; n++) begin
            rc = 2'($urandom_range(0, 3));
            for (int i = 0; i < NL; i++) begin
                case ($urandom_range(0, 5))
                    0: rp[i*DW +: DW] = 32'h7FFF_FFFF;
                    1: rp[i*DW +: DW] = 32'h8000_0000;
                    default: rp[i*DW +: DW] = $urandom;
                endcase
            end
            issue($urandom_range(0, 4) != 0, rc, rp, AW'($urandom));
        end
        idle(8);
        check("scoreboard_drained", VW'(sb_q.size()), '0);
        check("final_vector", out_data, model_vec());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
